// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead block per
// stage, operand skew lines between stages, valid/ready flow control.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / GROUP;

  // Returns {carry into MSB, carry out, sum bits}; every carry is a flat
  // sum-of-products of g/p/c0, never a ripple through the previous carry.
  function automatic logic [GROUP+1:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             c0);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             prod;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      prod = c0;
      for (int m = 0; m <= i; m++) prod = prod & p[m];
      c[i+1] = prod;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int m = j + 1; m <= i; m++) prod = prod & p[m];
        c[i+1] = c[i+1] | prod;
      end
    end
    return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  logic [NSTG-1:0]  valid_q;
  logic [NSTG-1:0]  carry_q;
  logic [WIDTH-1:0] opa_q [NSTG];
  logic [WIDTH-1:0] opb_q [NSTG];
  logic [WIDTH-1:0] res_q [NSTG];

  logic [NSTG-1:0]  vld_in;
  logic [NSTG-1:0]  cin_grp;
  logic [WIDTH-1:0] opa_in [NSTG];
  logic [WIDTH-1:0] opb_in [NSTG];
  logic [WIDTH-1:0] res_in [NSTG];
  logic [WIDTH-1:0] res_nx [NSTG];
  logic [GROUP+1:0] grp_out [NSTG];

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign b_eff    = b ^ {WIDTH{sub}};
  assign cin_eff  = cin ^ sub;

  // Operand pipes hold the not-yet-consumed upper bits shifted down, so each
  // stage always works on bits [GROUP-1:0] of its incoming operands.
  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign opa_in[k]  = a;
      assign opb_in[k]  = b_eff;
      assign res_in[k]  = '0;
      assign cin_grp[k] = cin_eff;
      assign vld_in[k]  = in_valid;
    end else begin : g_next
      assign opa_in[k]  = opa_q[k-1];
      assign opb_in[k]  = opb_q[k-1];
      assign res_in[k]  = res_q[k-1];
      assign cin_grp[k] = carry_q[k-1];
      assign vld_in[k]  = valid_q[k-1];
    end
    assign grp_out[k] = cla_group(opa_in[k][GROUP-1:0], opb_in[k][GROUP-1:0], cin_grp[k]);
    assign res_nx[k]  = res_in[k] | (WIDTH'(grp_out[k][GROUP-1:0]) << (k * GROUP));
  end

  // NOTE: the data pipes are reset too, because sum/cout/ovf must read 0 during
  // reset; without that a plain datapath register would not need a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= vld_in;
      for (int k = 0; k < NSTG; k++) begin
        if (vld_in[k]) begin
          opa_q[k]   <= opa_in[k] >> GROUP;
          opb_q[k]   <= opb_in[k] >> GROUP;
          res_q[k]   <= res_nx[k];
          carry_q[k] <= grp_out[k][GROUP];
        end
      end
      if (vld_in[NSTG-1]) ovf_q <= grp_out[NSTG-1][GROUP+1] ^ grp_out[NSTG-1][GROUP];
    end
  end

  assign out_valid = valid_q[NSTG-1];
  assign sum       = res_q[NSTG-1];
  assign cout      = carry_q[NSTG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, GROUP=4): directed
// vectors, asynchronous reset mid-stream, backpressure and a random stream.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  bit          sb_en = 1'b0;
  logic [17:0] exp_q[$];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10] = '{
    '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0},
    '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0}
  };

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] ye;
    logic [16:0] r;
    logic        v;
    ye = y ^ {16{s}};
    r  = {1'b0, x} + {1'b0, ye} + 17'(ci ^ s);
    v  = (x[15] == ye[15]) && (r[15] != x[15]);
    return {v, r[16], r[15:0]};
  endfunction

  // Scoreboard: both handshakes are sampled mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("queue_underflow", 32'(exp_q.size()), 1);
        else begin
          check("result", {ovf, cout, sum}, exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic single_op(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check($sformatf("vec%0d_latency", idx), lat, 4);
    check($sformatf("vec%0d_sum", idx), sum, v.sum);
    check($sformatf("vec%0d_cout", idx), cout, v.cout);
    check($sformatf("vec%0d_ovf", idx), ovf, v.ovf);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [15:0] hold;
    bit          fired;
    int          accepted;
    int          cyc;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed single operations
    for (int i = 0; i < 10; i++) single_op(vecs[i], i);

    // Asynchronous reset with ops in flight and a result on the output
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 16'hC000 : 16'(i) * 16'h1111;
      b = (i == 0) ? 16'h8001 : 16'h0101;
      cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sum", sum, 16'h4001);
    check("pre_rst_cout", cout, 1);
    check("pre_rst_ovf", ovf, 1);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_result", out_valid, 0);
    end

    // Backpressure: 8 back-to-back ops, then a 3-cycle stall with a 9th op offered
    n_out = 0;
    exp_q.delete();
    sb_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      a = 16'(i) * 16'h1111;
      b = 16'hF0F0 ^ 16'(i);
      cin = i[1]; sub = i[0]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    a = 16'hABCD; b = 16'h1234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    hold = sum;
    repeat (2) begin
      @(posedge clk); #2;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_sum_stable", sum, hold);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp_drain");
    check("bp_count", n_out, 9);

    // Random regression with random valid/ready on both sides
    n_out = 0;
    accepted = 0;
    cyc = 0;
    fired = 1'b0;
    while (accepted < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) accepted++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");
    check("rand_accepted", accepted, 10000);
    check("rand_count", n_out, accepted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
